mam_mem_arbiter: RTL and testbench

- Shares the single debug-memory request/write/read interface (req/write/read channel set driven by osd_mam) between N_REQ requesters, e.g. osd_mam plus a future trace or DMA debug module.
- Arbitrates per transaction and holds the grant until the last data beat of the granted burst completes.
- Routes the write and read data channels only to the granted requester.
- Sits in debug_system between the requester modules and the memory-side bridge.

---
 rtl/mam_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_mam_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mam_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mam_mem_arbiter
//
// Purpose:
//   Shares one debug-memory interface (request / write-data / read-data
//   channels) between N_REQ requesters.  A requester is granted per
//   transaction and keeps the grant until the last data beat of its burst has
//   handshaked.  All data and handshake paths are combinational muxes on the
//   registered grant, so the only latency added is the one-cycle grant
//   decision in IDLE.
//
// Configuration macro:
//   MAM_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid requester
//                           always wins and the round-robin pointer does not
//                           exist.  Undefined (default): round-robin starting
//                           at the requester after the last one served.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_req_*   [N_REQ]         per-requester request channel (addr/beats packed,
//                             requester i in slice i)
//   s_write_* [N_REQ]         per-requester write-data channel
//   s_read_valid/ready        per-requester read handshake
//   s_read_data               read data, broadcast to all requesters
//   m_req_*, m_write_*,
//   m_read_*                  memory-side channels
//   grant                     one-hot current owner, 0 while idle
//   busy                      high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mam_mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rstn,

  input  logic [N_REQ-1:0]              s_req_valid,
  output logic [N_REQ-1:0]              s_req_ready,
  input  logic [N_REQ-1:0]              s_req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [N_REQ-1:0]              s_req_burst,
  input  logic [N_REQ*14-1:0]           s_req_beats,

  input  logic [N_REQ-1:0]              s_write_valid,
  output logic [N_REQ-1:0]              s_write_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   s_write_data,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] s_write_strb,

  output logic [N_REQ-1:0]              s_read_valid,
  output logic [DATA_WIDTH-1:0]         s_read_data,
  input  logic [N_REQ-1:0]              s_read_ready,

  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic                          m_req_rw,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  output logic                          m_req_burst,
  output logic [13:0]                   m_req_beats,

  output logic                          m_write_valid,
  input  logic                          m_write_ready,
  output logic [DATA_WIDTH-1:0]         m_write_data,
  output logic [DATA_WIDTH/8-1:0]       m_write_strb,

  input  logic                          m_read_valid,
  input  logic [DATA_WIDTH-1:0]         m_read_data,
  output logic                          m_read_ready,

  output logic [N_REQ-1:0]              grant,
  output logic                          busy
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [13:0]        beats_q, beats_d;

  logic [N_REQ-1:0]   rot_valid;
  logic [N_REQ-1:0]   rot_pick;
  logic [N_REQ-1:0]   pick_oh;
  logic               pick_found;

  logic               sel_req_valid;
  logic               sel_write_valid;
  logic               sel_read_ready;
  logic               beat_done;

`ifndef MAM_ARB_FIXED_PRIO_EN
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      next_ptr;

  // Rotate the request vector so the requester at rr_ptr sits at bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner, and
  // rotating the one-hot pick back gives the winner in original numbering.
  always_comb begin
    rot_valid = N_REQ'({s_req_valid, s_req_valid} >> rr_ptr_q);
    pick_oh   = N_REQ'(({rot_pick, rot_pick} << rr_ptr_q) >> N_REQ);
  end

  // Pointer moves to the requester just after the one being released.
  always_comb begin
    next_ptr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        next_ptr = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end
`else
  always_comb begin
    rot_valid = s_req_valid;
    pick_oh   = rot_pick;
  end
`endif

  // Lowest set bit of the (possibly rotated) request vector.
  always_comb begin
    rot_pick   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot_valid[k] && !pick_found) begin
        rot_pick[k] = 1'b1;
        pick_found  = 1'b1;
      end
    end
  end

  // Channel muxes driven purely by the registered grant.  Non-owners always
  // see ready/valid low; handshakes are only forwarded in the state that owns
  // that channel.
  always_comb begin
    m_req_rw        = 1'b0;
    m_req_addr      = '0;
    m_req_burst     = 1'b0;
    m_req_beats     = '0;
    m_write_data    = '0;
    m_write_strb    = '0;
    sel_req_valid   = 1'b0;
    sel_write_valid = 1'b0;
    sel_read_ready  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        m_req_rw        = s_req_rw[i];
        m_req_addr      = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_req_burst     = s_req_burst[i];
        m_req_beats     = s_req_beats[i*14 +: 14];
        m_write_data    = s_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        m_write_strb    = s_write_strb[i*SW +: SW];
        sel_req_valid   = s_req_valid[i];
        sel_write_valid = s_write_valid[i];
        sel_read_ready  = s_read_ready[i];
      end
    end

    m_req_valid   = (state_q == ISSUE) && sel_req_valid;
    s_req_ready   = (state_q == ISSUE) ? (grant_q & {N_REQ{m_req_ready}}) : '0;
    m_write_valid = (state_q == WDATA) && sel_write_valid;
    s_write_ready = (state_q == WDATA) ? (grant_q & {N_REQ{m_write_ready}}) : '0;
    m_read_ready  = (state_q == RDATA) && sel_read_ready;
    s_read_valid  = (state_q == RDATA) ? (grant_q & {N_REQ{m_read_valid}}) : '0;
  end

  assign s_read_data = m_read_data;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);

  assign beat_done = ((state_q == WDATA) && m_write_valid && m_write_ready) ||
                     ((state_q == RDATA) && m_read_valid  && m_read_ready);

  // Next-state logic.  A burst with zero beats is treated as a single beat.
  // Leaving through IDLE after every transaction means a request raised during
  // the final beat is only arbitrated in the following IDLE cycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    beats_d  = beats_q;
`ifndef MAM_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|s_req_valid) begin
          grant_d = pick_oh;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_req_valid && m_req_ready) begin
          beats_d = (m_req_burst && (m_req_beats != 14'd0)) ? m_req_beats : 14'd1;
          state_d = m_req_rw ? WDATA : RDATA;
        end
      end
      WDATA, RDATA: begin
        if (beat_done) begin
          if (beats_q == 14'd1) begin
            state_d  = IDLE;
            grant_d  = '0;
`ifndef MAM_ARB_FIXED_PRIO_EN
            rr_ptr_d = next_ptr;
`endif
          end else begin
            beats_d = beats_q - 14'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      beats_q  <= '0;
`ifndef MAM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beats_q  <= beats_d;
`ifndef MAM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mam_mem_arbiter
//
// Scenario tasks drive requesters and a memory-side responder and compare the
// arbiter against a transaction-level model: the expected winner comes from a
// scan of the pending-request mask starting at the model's pointer, the
// expected beat count from the burst/beats fields.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mam_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    s_req_valid, s_req_ready, s_req_rw, s_req_burst;
  logic [N*AW-1:0] s_req_addr;
  logic [N*14-1:0] s_req_beats;
  logic [N-1:0]    s_write_valid, s_write_ready;
  logic [N*DW-1:0] s_write_data;
  logic [N*SW-1:0] s_write_strb;
  logic [N-1:0]    s_read_valid, s_read_ready;
  logic [DW-1:0]   s_read_data;
  logic            m_req_valid, m_req_ready, m_req_rw, m_req_burst;
  logic [AW-1:0]   m_req_addr;
  logic [13:0]     m_req_beats;
  logic            m_write_valid, m_write_ready;
  logic [DW-1:0]   m_write_data;
  logic [SW-1:0]   m_write_strb;
  logic            m_read_valid, m_read_ready;
  logic [DW-1:0]   m_read_data;
  logic [N-1:0]    grant;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int mrr   = 0;

  mam_mem_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
    .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
    .s_write_valid(s_write_valid), .s_write_ready(s_write_ready),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ready(s_read_ready),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_rw(m_req_rw),
    .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
    .m_write_valid(m_write_valid), .m_write_ready(m_write_ready),
    .m_write_data(m_write_data), .m_write_strb(m_write_strb),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ready(m_read_ready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Each cycle body starts 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Arbitration rule of the model.
  function automatic int exp_win(input logic [N-1:0] mask);
`ifdef MAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (mask[k]) return k;
`else
    for (int k = 0; k < N; k++) if (mask[(mrr + k) % N]) return (mrr + k) % N;
`endif
    return -1;
  endfunction

  function automatic int exp_beats(input bit burst, input int beats);
    return (burst && beats != 0) ? beats : 1;
  endfunction

  function automatic logic [N-1:0] onehot(input int r);
    return N'(1) << r;
  endfunction

  task automatic set_req(input int r, input bit rw, input bit burst, input int beats,
                         input logic [AW-1:0] addr);
    s_req_valid = s_req_valid | onehot(r);
    s_req_rw    = (s_req_rw & ~onehot(r)) | (rw ? onehot(r) : '0);
    s_req_burst = (s_req_burst & ~onehot(r)) | (burst ? onehot(r) : '0);
    s_req_beats[r*14 +: 14] = 14'(beats);
    s_req_addr[r*AW +: AW]  = addr;
  endtask

  // Request phase: m_req_ready held low for rdy_delay cycles, then high.
  task automatic req_phase(input int rdy_delay, output logic [N-1:0] g_obs,
                           output logic [AW-1:0] a_obs, output logic rw_obs,
                           output logic burst_obs, output logic [13:0] beats_obs,
                           output int cyc, output int mirror_bad, output bit timeout);
    bit hs;
    hs = 0; g_obs = '0; a_obs = '0; rw_obs = 0; burst_obs = 0; beats_obs = '0;
    cyc = -1; mirror_bad = 0; timeout = 1;
    for (int c = 0; c < 60; c++) begin
      m_req_ready = (c >= rdy_delay);
      #1;
      if (m_req_valid && (s_req_ready !== (grant & {N{m_req_ready}}))) mirror_bad++;
      if (m_req_valid && m_req_ready) begin
        g_obs = grant; a_obs = m_req_addr; rw_obs = m_req_rw;
        burst_obs = m_req_burst; beats_obs = m_req_beats; cyc = c; hs = 1;
      end
      tick();
      if (hs) begin
        s_req_valid = s_req_valid & ~g_obs;
        timeout = 0;
        break;
      end
    end
    m_req_ready = 1'b0;
  endtask

  // Data phase for owner r. mode 0: random handshakes, 1: toggling memory
  // ready, 2: always valid/ready.  stop_after != 0 returns after that many beats.
  task automatic data_phase(input int r, input bit rw, input int mode, input int stop_after,
                            input logic [DW-1:0] base, output int seen, output int data_bad,
                            output int tail, output bit timeout);
    logic [N-1:0] rm;
    int last;
    rm = onehot(r); last = 0; seen = 0; data_bad = 0; tail = -1; timeout = 1;
    for (int c = 0; c < 300; c++) begin
      bit hs;
      bit v;
      hs = 0;
      if (rw) begin
        v = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_write_valid = ~rm | (v ? rm : '0);
        s_write_data  = {N{~base}};
        s_write_strb  = '0;
        s_write_data[r*DW +: DW] = base + DW'(seen);
        s_write_strb[r*SW +: SW] = SW'(seen + 1);
        m_write_ready = (mode == 2) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      end else begin
        m_read_valid = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        m_read_data  = $urandom;
        s_read_ready = (mode == 2) ? '1 : N'($urandom);
      end
      #1;
      if (rw) begin
        if (s_write_ready !== (rm & {N{m_write_ready}})) data_bad++;
        if (m_write_valid !== v) data_bad++;
        if (m_write_valid && m_write_ready) begin
          if (m_write_data !== base + DW'(seen) || m_write_strb !== SW'(seen + 1)) data_bad++;
          hs = 1;
        end
      end else begin
        if (s_read_data !== m_read_data) data_bad++;
        if (s_read_valid !== (rm & {N{m_read_valid}})) data_bad++;
        if (m_read_ready !== (|(s_read_ready & rm))) data_bad++;
        if (m_read_valid && m_read_ready) hs = 1;
      end
      if (hs) begin
        seen++;
        last = c;
      end
      tick();
      if (stop_after != 0 && seen >= stop_after) begin
        timeout = 0;
        break;
      end
      if (!busy) begin
        tail = c + 1 - last;
        timeout = 0;
        break;
      end
    end
    s_write_valid = '0; m_write_ready = 1'b0; m_read_valid = 1'b0; s_read_ready = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_req_valid = '1; s_req_rw = '0; s_req_burst = '0; s_req_beats = '0; s_req_addr = '0;
    s_write_valid = '1; s_write_data = '0; s_write_strb = '0; s_read_ready = '1;
    m_req_ready = 1'b1; m_write_ready = 1'b1; m_read_valid = 1'b1; m_read_data = '0;
    repeat (3) tick();
    total++; if (grant !== '0) begin bad++; $display("[TB] FAIL reset_grant: got %b expected 0", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if ({m_req_valid, m_write_valid, m_read_ready} !== 3'b000) begin bad++; $display("[TB] FAIL reset_m_ctrl: got %b expected 000", {m_req_valid, m_write_valid, m_read_ready}); end
    total++; if ({s_req_ready, s_write_ready, s_read_valid} !== '0) begin bad++; $display("[TB] FAIL reset_s_ctrl: got %b expected 0", {s_req_ready, s_write_ready, s_read_valid}); end
    s_req_valid = '0; s_write_valid = '0; s_read_ready = '0;
    m_req_ready = 1'b0; m_write_ready = 1'b0; m_read_valid = 1'b0;
    rstn = 1'b1;
    mrr = 0;
    tick(); tick();
    total++; if ({busy, grant} !== '0) begin bad++; $display("[TB] FAIL idle_no_req: got %b expected 0", {busy, grant}); end
  endtask

  task automatic test_contention();
    int exp_seq[4];
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail; bit to;
    logic [AW-1:0] addrs[N];
`ifdef MAM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    addrs[0] = 16'h1000; addrs[1] = 16'h2000;
    set_req(0, 1, 0, 0, addrs[0]);
    set_req(1, 1, 0, 0, addrs[1]);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = exp_seq[k];
      req_phase(0, g, a, rw, bu, be, cyc, mb, to);
      total++; if (g !== onehot(w) || to) begin bad++; $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, g, onehot(w)); end
      total++; if (a !== addrs[w]) begin bad++; $display("[TB] FAIL contention_addr%0d: got %h expected %h", k, a, addrs[w]); end
      if (k < 3) set_req(w, 1, 0, 0, addrs[w]);
      else s_req_valid = '0;
      data_phase(w, 1, 2, 0, 32'hC0DE_0000 + k, seen, db, tail, to);
      total++; if (seen !== 1 || db !== 0 || to) begin bad++; $display("[TB] FAIL contention_beats%0d: got %0d (errs %0d) expected 1", k, seen, db); end
      mrr = (w + 1) % N;
    end
  endtask

  task automatic test_single_read();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail; bit to;
    set_req(0, 0, 1, 4, 16'h0400);
    req_phase(0, g, a, rw, bu, be, cyc, mb, to);
    total++; if (g !== 2'b01 || to) begin bad++; $display("[TB] FAIL read_grant: got %b expected 01", g); end
    total++; if (cyc !== 1) begin bad++; $display("[TB] FAIL read_req_latency: got %0d expected 1", cyc); end
    total++; if (rw !== 1'b0 || be !== 14'd4 || a !== 16'h0400) begin bad++; $display("[TB] FAIL read_req_fields: got rw=%b beats=%0d addr=%h expected 0/4/0400", rw, be, a); end
    data_phase(0, 0, 0, 0, '0, seen, db, tail, to);
    total++; if (seen !== 4 || to) begin bad++; $display("[TB] FAIL read_beats: got %0d expected 4", seen); end
    total++; if (db !== 0) begin bad++; $display("[TB] FAIL read_routing: got %0d errors expected 0", db); end
    total++; if (tail !== 1) begin bad++; $display("[TB] FAIL read_busy_drop: got %0d cycles expected 1", tail); end
    mrr = 1;
  endtask

  task automatic test_zero_beat();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail, w; bit to;
    w = exp_win(2'b10);
    set_req(1, 1, 1, 0, 16'h0ABC);
    req_phase(1, g, a, rw, bu, be, cyc, mb, to);
    total++; if (g !== onehot(w) || bu !== 1'b1 || be !== 14'd0 || to) begin bad++; $display("[TB] FAIL zero_req: got g=%b burst=%b beats=%0d expected %b/1/0", g, bu, be, onehot(w)); end
    data_phase(1, 1, 2, 0, 32'h5A5A_0000, seen, db, tail, to);
    total++; if (seen !== 1 || db !== 0 || tail !== 1 || to) begin bad++; $display("[TB] FAIL zero_beats: got %0d beats (errs %0d, tail %0d) expected 1", seen, db, tail); end
    mrr = (w + 1) % N;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail, w; bit to;
    w = exp_win(2'b01);
    set_req(0, 1, 1, 8, 16'h0800);
    req_phase(6, g, a, rw, bu, be, cyc, mb, to);
    total++; if (g !== onehot(w) || cyc !== 6 || to) begin bad++; $display("[TB] FAIL bp_req: got g=%b cyc=%0d expected %b/6", g, cyc, onehot(w)); end
    total++; if (mb !== 0) begin bad++; $display("[TB] FAIL bp_ready_mirror: got %0d errors expected 0", mb); end
    data_phase(0, 1, 1, 0, 32'hBEEF_0000, seen, db, tail, to);
    total++; if (seen !== 8 || to) begin bad++; $display("[TB] FAIL bp_beats: got %0d expected 8", seen); end
    total++; if (db !== 0 || tail !== 1) begin bad++; $display("[TB] FAIL bp_data: got %0d errors tail %0d expected 0/1", db, tail); end
    mrr = (w + 1) % N;
  endtask

  task automatic test_reset_mid_burst();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail, w; bit to;
    set_req(0, 0, 1, 8, 16'h0C00);
    req_phase(0, g, a, rw, bu, be, cyc, mb, to);
    data_phase(0, 0, 2, 2, '0, seen, db, tail, to);
    total++; if (seen !== 2 || busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre: got beats=%0d busy=%b expected 2/1", seen, busy); end
    s_req_valid = '1; m_req_ready = 1'b1; m_read_valid = 1'b1; s_read_ready = '1;
    s_write_valid = '1; m_write_ready = 1'b1;
    #1 rstn = 1'b0;
    #1;
    total++; if ({grant, busy} !== '0) begin bad++; $display("[TB] FAIL midrst_async: got grant=%b busy=%b expected 0/0", grant, busy); end
    total++; if ({s_read_valid, m_read_ready, s_req_ready, m_req_valid, s_write_ready, m_write_valid} !== '0) begin bad++; $display("[TB] FAIL midrst_outputs: got %b expected 0", {s_read_valid, m_read_ready, s_req_ready, m_req_valid, s_write_ready, m_write_valid}); end
    tick();
    s_req_valid = '0; m_req_ready = 1'b0; m_read_valid = 1'b0; s_read_ready = '0;
    s_write_valid = '0; m_write_ready = 1'b0;
    rstn = 1'b1;
    mrr = 0;
    tick();
    total++; if ({grant, busy} !== '0) begin bad++; $display("[TB] FAIL midrst_after: got %b expected 0", {grant, busy}); end
    set_req(0, 0, 0, 0, 16'h0011);
    set_req(1, 0, 0, 0, 16'h0022);
    w = exp_win(2'b11);
    req_phase(0, g, a, rw, bu, be, cyc, mb, to);
    s_req_valid = '0;
    total++; if (g !== onehot(w) || to) begin bad++; $display("[TB] FAIL midrst_ptr: got %b expected %b", g, onehot(w)); end
    data_phase(w, 0, 2, 0, '0, seen, db, tail, to);
    total++; if (seen !== 1 || db !== 0 || to) begin bad++; $display("[TB] FAIL midrst_txn: got %0d beats expected 1", seen); end
    mrr = (w + 1) % N;
  endtask

  task automatic test_late_arrival();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail; bit to;
    set_req(0, 1, 0, 0, 16'h3000);
    req_phase(0, g, a, rw, bu, be, cyc, mb, to);
    total++; if (g !== 2'b01 || to) begin bad++; $display("[TB] FAIL late_first_grant: got %b expected 01", g); end
    set_req(1, 0, 0, 0, 16'h4321);
    data_phase(0, 1, 2, 0, 32'h1234_0000, seen, db, tail, to);
    total++; if (seen !== 1 || tail !== 1 || to) begin bad++; $display("[TB] FAIL late_first_beats: got %0d tail %0d expected 1/1", seen, tail); end
    total++; if ({grant, busy} !== '0) begin bad++; $display("[TB] FAIL late_idle_cycle: got %b expected 0", {grant, busy}); end
    mrr = 1;
    tick();
    total++; if (grant !== 2'b10 || m_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL late_grant: got %b valid %b expected 10/1", grant, m_req_valid); end
    total++; if (m_req_addr !== 16'h4321) begin bad++; $display("[TB] FAIL late_addr: got %h expected 4321", m_req_addr); end
    req_phase(0, g, a, rw, bu, be, cyc, mb, to);
    data_phase(1, 0, 2, 0, '0, seen, db, tail, to);
    total++; if (seen !== 1 || db !== 0 || to) begin bad++; $display("[TB] FAIL late_second_beats: got %0d expected 1", seen); end
    mrr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] g; logic [AW-1:0] a; logic rw, bu; logic [13:0] be;
    int cyc, mb, seen, db, tail, w, eb; bit to;
    for (int it = 0; it < 16; it++) begin
      for (int r = 0; r < N; r++) begin
        if (!s_req_valid[r] && $urandom_range(0, 1) == 1)
          set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5), AW'($urandom));
      end
      if (s_req_valid == '0)
        set_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5), AW'($urandom));
      w  = exp_win(s_req_valid);
      eb = exp_beats(s_req_burst[w], int'(s_req_beats[w*14 +: 14]));
      req_phase($urandom_range(0, 3), g, a, rw, bu, be, cyc, mb, to);
      total++; if (g !== onehot(w) || to) begin bad++; $display("[TB] FAIL rand_grant%0d: got %b expected %b", it, g, onehot(w)); end
      total++; if (a !== s_req_addr[w*AW +: AW] || rw !== s_req_rw[w] || mb !== 0) begin bad++; $display("[TB] FAIL rand_req%0d: got addr=%h rw=%b expected %h/%b", it, a, rw, s_req_addr[w*AW +: AW], s_req_rw[w]); end
      data_phase(w, s_req_rw[w], 0, 0, DW'($urandom), seen, db, tail, to);
      total++; if (seen !== eb || db !== 0 || to) begin bad++; $display("[TB] FAIL rand_beats%0d: got %0d (errs %0d) expected %0d", it, seen, db, eb); end
      mrr = (w + 1) % N;
    end
    s_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_zero_beat();
    test_backpressure();
    test_reset_mid_burst();
    test_late_arrival();
    test_random();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
